// File: rtl/wide_arith_sequencer.sv
// rtl/wide_arith_sequencer.sv - runs one 32-bit ADD/LSL/LSR/AND as two chained 16-bit ALU passes
module wide_arith_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        StartValid,
  output logic        StartReady,
  input  logic [1:0]  Op,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  output logic [15:0] AluA,
  output logic [15:0] AluB,
  output logic [4:0]  AluFunSel,
  output logic        AluWF,
  input  logic [15:0] AluOut,
  input  logic [3:0]  AluFlags,
  output logic [31:0] Result,
  output logic [3:0]  ResultFlags,
  output logic        ResultValid,
  input  logic        ResultReady
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_FLAG = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LSL = 2'b01;
  localparam logic [1:0] OP_LSR = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam logic [4:0] FS_IDLE = 5'b10000;
  localparam logic [4:0] FS_ADD  = 5'b10100;
  localparam logic [4:0] FS_ADC  = 5'b10101;
  localparam logic [4:0] FS_AND  = 5'b10111;
  localparam logic [4:0] FS_LSL  = 5'b11011;
  localparam logic [4:0] FS_LSR  = 5'b11100;
  localparam logic [4:0] FS_CSL  = 5'b11110;
  localparam logic [4:0] FS_CSR  = 5'b11111;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  rflags_q, rflags_d;
  logic        result_valid_q, result_valid_d;
  logic        start_ready_q, start_ready_d;

  logic        flag_z, flag_c, flag_n, flag_o;

  // 32-bit flags: Z and N come from the whole result, C/O from the high pass only where meaningful
  always_comb begin
    flag_z = (result_q == 32'd0);
    flag_n = result_q[31];
    flag_c = 1'b0;
    flag_o = 1'b0;
    case (op_q)
      OP_ADD: begin
        flag_c = AluFlags[2];
        flag_o = AluFlags[0];
      end
      OP_LSL, OP_LSR: flag_c = AluFlags[2];
      default: begin
        flag_c = 1'b0;
        flag_o = 1'b0;
      end
    endcase
  end

  // Next-state, request capture and result assembly
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    rflags_d = rflags_q;
    case (state_q)
      S_IDLE: begin
        if (StartValid) begin
          op_d    = Op;
          opa_d   = OpA;
          opb_d   = OpB;
          state_d = S_P1;
        end
      end
      S_P1: begin
        // LSR works high word first so the carry moves down into the low word
        if (op_q == OP_LSR) result_d[31:16] = AluOut;
        else                result_d[15:0]  = AluOut;
        state_d = S_P2;
      end
      S_P2: begin
        if (op_q == OP_LSR) result_d[15:0]  = AluOut;
        else                result_d[31:16] = AluOut;
        state_d = S_FLAG;
      end
      S_FLAG: begin
        rflags_d = {flag_z, flag_c, flag_n, flag_o};
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (ResultReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    result_valid_d = (state_d == S_DONE);
    start_ready_d  = (state_d == S_IDLE);
  end

  // State and registered handshake outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      op_q           <= 2'b00;
      opa_q          <= 32'd0;
      opb_q          <= 32'd0;
      result_q       <= 32'd0;
      rflags_q       <= 4'd0;
      result_valid_q <= 1'b0;
      start_ready_q  <= 1'b1;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      result_q       <= result_d;
      rflags_q       <= rflags_d;
      result_valid_q <= result_valid_d;
      start_ready_q  <= start_ready_d;
    end
  end

  // ALU drive: operand words and function per pass; flags are written only in P1/P2
  always_comb begin
    AluA      = 16'd0;
    AluB      = 16'd0;
    AluFunSel = FS_IDLE;
    AluWF     = 1'b0;
    case (state_q)
      S_P1: begin
        AluWF = 1'b1;
        case (op_q)
          OP_ADD: begin AluA = opa_q[15:0];  AluB = opb_q[15:0]; AluFunSel = FS_ADD; end
          OP_LSL: begin AluA = opa_q[15:0];  AluFunSel = FS_LSL; end
          OP_LSR: begin AluA = opa_q[31:16]; AluFunSel = FS_LSR; end
          default: begin AluA = opa_q[15:0]; AluB = opb_q[15:0]; AluFunSel = FS_AND; end
        endcase
      end
      S_P2: begin
        AluWF = 1'b1;
        case (op_q)
          OP_ADD: begin AluA = opa_q[31:16]; AluB = opb_q[31:16]; AluFunSel = FS_ADC; end
          OP_LSL: begin AluA = opa_q[31:16]; AluFunSel = FS_CSL; end
          OP_LSR: begin AluA = opa_q[15:0];  AluFunSel = FS_CSR; end
          default: begin AluA = opa_q[31:16]; AluB = opb_q[31:16]; AluFunSel = FS_AND; end
        endcase
      end
      default: begin
        AluA      = 16'd0;
        AluB      = 16'd0;
        AluFunSel = FS_IDLE;
        AluWF     = 1'b0;
      end
    endcase
  end

  assign StartReady  = start_ready_q;
  assign Result      = result_q;
  assign ResultFlags = rflags_q;
  assign ResultValid = result_valid_q;

endmodule

// File: tb/tb_wide_arith_sequencer.sv
// tb/tb_wide_arith_sequencer.sv - directed table-driven bench for wide_arith_sequencer with a 16-bit ALU model
module tb_wide_arith_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        StartValid;
  logic        StartReady;
  logic [1:0]  Op;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic [15:0] AluA;
  logic [15:0] AluB;
  logic [4:0]  AluFunSel;
  logic        AluWF;
  logic [15:0] AluOut;
  logic [3:0]  AluFlags;
  logic [31:0] Result;
  logic [3:0]  ResultFlags;
  logic        ResultValid;
  logic        ResultReady;

  int passed = 0;
  int total  = 0;

  wide_arith_sequencer dut (
    .Clock(Clock), .Reset(Reset),
    .StartValid(StartValid), .StartReady(StartReady),
    .Op(Op), .OpA(OpA), .OpB(OpB),
    .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
    .AluOut(AluOut), .AluFlags(AluFlags),
    .Result(Result), .ResultFlags(ResultFlags),
    .ResultValid(ResultValid), .ResultReady(ResultReady)
  );

  always #5 Clock = ~Clock;

  // 16-bit ALU model: combinational output, registered {Z,C,N,O} written when WF is high
  logic [16:0] alu_sum;
  logic        alu_c_new;
  logic        alu_o_new;
  logic        alu_touch_o;
  logic        alu_touch_c;
  always_comb begin
    alu_sum     = 17'd0;
    AluOut      = 16'd0;
    alu_c_new   = AluFlags[2];
    alu_o_new   = AluFlags[0];
    alu_touch_c = 1'b0;
    alu_touch_o = 1'b0;
    case (AluFunSel)
      5'b10100, 5'b10101: begin
        alu_sum = {1'b0, AluA} + {1'b0, AluB} + {16'd0, (AluFunSel == 5'b10101) ? AluFlags[2] : 1'b0};
        AluOut  = alu_sum[15:0];
        alu_c_new = alu_sum[16];
        alu_o_new = (AluA[15] == AluB[15]) && (alu_sum[15] != AluA[15]);
        alu_touch_c = 1'b1;
        alu_touch_o = 1'b1;
      end
      5'b10111: AluOut = AluA & AluB;
      5'b11011: begin AluOut = {AluA[14:0], 1'b0};        alu_c_new = AluA[15]; alu_touch_c = 1'b1; end
      5'b11110: begin AluOut = {AluA[14:0], AluFlags[2]}; alu_c_new = AluA[15]; alu_touch_c = 1'b1; end
      5'b11100: begin AluOut = {1'b0, AluA[15:1]};        alu_c_new = AluA[0];  alu_touch_c = 1'b1; end
      5'b11111: begin AluOut = {AluFlags[2], AluA[15:1]}; alu_c_new = AluA[0];  alu_touch_c = 1'b1; end
      default:  AluOut = AluA;
    endcase
  end

  initial AluFlags = 4'd0;
  always @(posedge Clock) begin
    if (AluWF) begin
      AluFlags[3] <= (AluOut == 16'd0);
      AluFlags[1] <= AluOut[15];
      if (alu_touch_c) AluFlags[2] <= alu_c_new;
      if (alu_touch_o) AluFlags[0] <= alu_o_new;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic [3:0]  exp_flags;
    logic [4:0]  fs1;
    logic [4:0]  fs2;
    int          hold;
  } vec_t;

  vec_t vecs[6];

  // Run one operation from IDLE, checking per-cycle ALU drive, latency, result and handshake
  task automatic run_op(input vec_t v);
    logic [31:0] held;
    StartValid = 1'b1;
    Op = v.op; OpA = v.a; OpB = v.b;
    ResultReady = 1'b0;
    chk({v.name, " start_ready"}, {31'd0, StartReady}, 32'd1);
    step();
    StartValid = 1'b0;
    Op = ~v.op; OpA = $urandom; OpB = $urandom;
    chk({v.name, " p1_funsel"}, {27'd0, AluFunSel}, {27'd0, v.fs1});
    chk({v.name, " p1_wf"}, {31'd0, AluWF}, 32'd1);
    chk({v.name, " p1_valid"}, {31'd0, ResultValid}, 32'd0);
    step();
    chk({v.name, " p2_funsel"}, {27'd0, AluFunSel}, {27'd0, v.fs2});
    chk({v.name, " p2_wf"}, {31'd0, AluWF}, 32'd1);
    chk({v.name, " p2_busy"}, {31'd0, StartReady}, 32'd0);
    step();
    chk({v.name, " flag_wf"}, {31'd0, AluWF}, 32'd0);
    chk({v.name, " flag_valid"}, {31'd0, ResultValid}, 32'd0);
    step();
    chk({v.name, " done_valid"}, {31'd0, ResultValid}, 32'd1);
    chk({v.name, " result"}, Result, v.exp_result);
    chk({v.name, " flags"}, {28'd0, ResultFlags}, {28'd0, v.exp_flags});
    chk({v.name, " done_wf"}, {31'd0, AluWF}, 32'd0);
    held = Result;
    for (int i = 0; i < v.hold; i++) begin
      StartValid = 1'b1;
      step();
      chk({v.name, " hold_valid"}, {31'd0, ResultValid}, 32'd1);
      chk({v.name, " hold_result"}, Result, held);
      chk({v.name, " hold_start_ready"}, {31'd0, StartReady}, 32'd0);
    end
    StartValid = 1'b0;
    ResultReady = 1'b1;
    step();
    ResultReady = 1'b0;
    chk({v.name, " back_idle_ready"}, {31'd0, StartReady}, 32'd1);
    chk({v.name, " back_idle_valid"}, {31'd0, ResultValid}, 32'd0);
  endtask

  initial begin
    // flags ordered {Z,C,N,O}
    vecs[0] = '{"add_carry",  2'b00, 32'h0000FFFF, 32'h00000001, 32'h00010000, 4'b0000, 5'b10100, 5'b10101, 0};
    vecs[1] = '{"add_wrap",   2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100, 5'b10100, 5'b10101, 0};
    vecs[2] = '{"add_ovf",    2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011, 5'b10100, 5'b10101, 0};
    vecs[3] = '{"lsl",        2'b01, 32'h80008000, 32'h12345678, 32'h00010000, 4'b0100, 5'b11011, 5'b11110, 0};
    vecs[4] = '{"lsr",        2'b10, 32'h00010001, 32'hDEADBEEF, 32'h00008000, 4'b0100, 5'b11100, 5'b11111, 0};
    vecs[5] = '{"and_bp",     2'b11, 32'hF0F00000, 32'h0F0FFFFF, 32'h00000000, 4'b1000, 5'b10111, 5'b10111, 5};

    Reset = 1'b1; StartValid = 1'b0; ResultReady = 1'b0;
    Op = 2'b00; OpA = 32'd0; OpB = 32'd0;
    step(); step();
    chk("reset_result", Result, 32'd0);
    chk("reset_flags", {28'd0, ResultFlags}, 32'd0);
    chk("reset_valid", {31'd0, ResultValid}, 32'd0);
    chk("reset_wf", {31'd0, AluWF}, 32'd0);
    chk("reset_funsel", {27'd0, AluFunSel}, 32'h10);
    Reset = 1'b0;
    step();
    chk("idle_ready", {31'd0, StartReady}, 32'd1);

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // Reset during P2 of an ADD32
    StartValid = 1'b1; Op = 2'b00; OpA = 32'h0000FFFF; OpB = 32'h00000001;
    step();
    StartValid = 1'b0;
    step();
    chk("rst_mid_in_p2", {27'd0, AluFunSel}, 32'h15);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rst_mid_valid", {31'd0, ResultValid}, 32'd0);
    chk("rst_mid_result", Result, 32'd0);
    chk("rst_mid_wf", {31'd0, AluWF}, 32'd0);
    chk("rst_mid_ready", {31'd0, StartReady}, 32'd1);
    step();
    chk("rst_mid_wf_after", {31'd0, AluWF}, 32'd0);
    run_op('{"add_after_rst", 2'b00, 32'h00000003, 32'h00000004, 32'h00000007, 4'b0000, 5'b10100, 5'b10101, 0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wide_arith_sequencer.md
Name: wide_arith_sequencer

Overview:
- Upstream/downstream companion to the 16-bit ALU: accepts one 32-bit operation request and executes it as two back-to-back 16-bit ALU passes.
- Drives the ALU's A, B, FunSel and WF inputs, and consumes its ALUOut and FlagsOut.
- Chains the passes through the ALU's registered carry flag (ADD then ADC, LSL then CSL, LSR then CSR).
- Returns the 32-bit result and 32-bit flags over a valid/ready handshake.

Parameters:
- None. Widths are fixed: 32-bit operands, 16-bit ALU.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- StartValid  in  1  request valid
- StartReady  out  1  sequencer can accept a request
- Op  in  2  00 ADD32, 01 LSL32, 10 LSR32, 11 AND32
- OpA  in  32  first operand (the only operand for shifts)
- OpB  in  32  second operand (ignored for shifts)
- AluA  out  16  to ALU A
- AluB  out  16  to ALU B
- AluFunSel  out  5  to ALU FunSel
- AluWF  out  1  to ALU WF
- AluOut  in  16  from ALU ALUOut
- AluFlags  in  4  from ALU FlagsOut, ordered {Z,C,N,O}
- Result  out  32  32-bit result
- ResultFlags  out  4  {Z,C,N,O} of the 32-bit result
- ResultValid  out  1  Result/ResultFlags valid
- ResultReady  in  1  consumer accepts result

Behaviour:
- Clock and reset: single clock `Clock`; `Reset` is synchronous, active-high.
- Reset values:
  - State = IDLE; Result = 0; ResultFlags = 0; ResultValid = 0.
  - Captured Op/OpA/OpB registers = 0.
- ALU drive outputs are decoded combinationally from state and the captured request.
  - In IDLE, FLAG and DONE: AluA = 0, AluB = 0, AluFunSel = 5'b10000, AluWF = 0.
- StartReady = 1 only in IDLE.
- A handshake occurs when StartValid && StartReady at a rising edge: Op, OpA and OpB are captured, then IDLE -> P1.
- P1 (first pass): AluWF = 1. AluOut is captured into the first-pass result half at the edge. P1 -> P2.
  - ADD32: low words, FunSel 10100.
  - LSL32: low word of A, FunSel 11011.
  - LSR32: high word of A, FunSel 11100.
  - AND32: low words, FunSel 10111.
- P2 (second pass): AluWF = 1. The ALU consumes the C written at the end of P1. AluOut is captured into the other result half. P2 -> FLAG.
  - ADD32: high words, FunSel 10101 (ADC).
  - LSL32: high word, FunSel 11110 (CSL).
  - LSR32: low word, FunSel 11111 (CSR).
  - AND32: high words, FunSel 10111.
- FLAG: AluWF = 0; ResultFlags is loaded at the edge, then FLAG -> DONE.
  - Z = (Result == 0) over all 32 bits. The ALU Z is ignored because it covers only the last word.
  - N = Result[31].
  - ADD32: C and O are taken from AluFlags, i.e. the high-pass flags.
  - LSL32/LSR32: C is taken from AluFlags; O = 0.
  - AND32: C = 0, O = 0.
- DONE: ResultValid = 1. Result and ResultFlags are held stable until ResultValid && ResultReady at an edge, then DONE -> IDLE.
  - No request is accepted in DONE.
  - A new request can be accepted on the first cycle back in IDLE.
- Latency: 4 cycles from the accepting edge to ResultValid high (P1, P2, FLAG, then DONE visible). Throughput is one operation per 5 cycles with ResultReady held high.
- Result ordering:
  - ADD32, LSL32, AND32: P1 fills Result[15:0], P2 fills Result[31:16].
  - LSR32: P1 fills Result[31:16], P2 fills Result[15:0].
- Request inputs are sampled only at the handshake; later changes to them are ignored.
- The sequencer is the sole writer of ALU flags. No other block asserts WF while the sequencer is outside IDLE.
- Reset mid-operation: at the reset edge, state goes to IDLE with ResultValid = 0, and AluWF = 0 from the next cycle on.
  - The ALU flags may have been written during the reset cycle; the sequencer never relies on pre-request flag values.
- Initial X on ALU FlagsOut is harmless: every operation's first pass writes C before P2 reads it.

Test Plan:
- ADD32 carry across words: A = 0x0000FFFF, B = 0x00000001 -> Result 0x00010000, flags Z0 C0 N0 O0, ResultValid 4 cycles after accept.
- ADD32 wrap and signed overflow:
  - 0xFFFFFFFF + 0x00000001 -> Result 0x00000000, flags Z1 C1 N0 O0.
  - 0x7FFFFFFF + 0x00000001 -> Result 0x80000000, flags Z0 C0 N1 O1.
- Shift chaining:
  - LSL32 A = 0x80008000 -> Result 0x00010000, C1 N0 Z0.
  - LSR32 A = 0x00010001 -> Result 0x00008000, C1 N0 Z0.
  - Check FunSel sequences 11011/11110 and 11100/11111 respectively, with AluWF = 1 only in P1/P2.
- AND32 and backpressure: A = 0xF0F00000, B = 0x0F0FFFFF -> Result 0x00000000, flags Z1 C0 N0 O0.
  - Hold ResultReady = 0 for 5 cycles: ResultValid and Result stay stable and StartReady stays 0.
  - Raise ResultReady: return to IDLE and StartReady = 1 next cycle.
- Reset mid-operation: assert Reset during P2 of an ADD32 -> next cycle IDLE, ResultValid 0, Result 0, AluWF 0.
  - A following ADD32 of 0x00000003 + 0x00000004 -> Result 0x00000007, flags all 0.
